bg_scaler_renderer: RTL and testbench

- Parametrised full-screen background renderer; next generation of the stretched background ROM reader.
- Replaces per-pixel multiply/divide addressing with incremental DDA accumulators.
- Adds stretch/tile modes, per-frame latched scroll offsets with wrap-around, a fixed-latency pipeline with delayed blank, and a transparency flag for layering.
- Sits between the VGA controller (DrawX/DrawY/blank) and an external synchronous sprite ROM plus a combinational palette.

---
 rtl/bg_render_pkg.sv | 26 ++
 rtl/bg_dda_axis.sv | 83 ++++++++
 rtl/bg_scaler_renderer.sv | 167 ++++++++++++++++
 tb/tb_bg_scaler_renderer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bg_render_pkg.sv
// Shared types and constants for the background renderer.
package bg_render_pkg;

  // Frame rendering mode, latched once per frame.
  typedef enum logic {
    MODE_STRETCH = 1'b0,
    MODE_TILE    = 1'b1
  } bg_mode_e;

  // Pixel-in to colour-out latency: DDA state, ROM address, ROM data, output register.
  localparam int RENDER_LATENCY = 3;

  // Default visible screen size.
  localparam int SCR_W_DEFAULT = 640;
  localparam int SCR_H_DEFAULT = 480;

  // Scroll inputs are 10 bits wide, so they never exceed this range.
  localparam int SCROLL_RANGE = 1024;

  // Conditional subtracts needed to reduce any scroll value below src:
  // (SCROLL_RANGE-1)/src, i.e. 2 for a 400-wide and 3 for a 300-high source.
  function automatic int mod_stages(input int src);
    return (SCROLL_RANGE - 1) / src;
  endfunction

endpackage

// File: rtl/bg_dda_axis.sv
// One axis of the scaler: source position, Bresenham-style error term and a
// linear address contribution (position * STRIDE) tracked with adds only.
module bg_dda_axis #(
  parameter int SRC    = 400,   // source extent along this axis
  parameter int SCR    = 640,   // screen extent along this axis (SRC <= SCR)
  parameter int STRIDE = 1,     // address weight of one source step
  parameter int W      = 10,    // position / offset width
  parameter int AW     = 17     // address contribution width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart_i,   // load offset, clear error
  input  logic          advance_i,   // one screen pixel/row elapsed
  input  logic          tile_i,      // 1: step every advance; 0: stretch
  input  logic [W-1:0]  offset_i,    // start position, already < SRC
  output logic [AW-1:0] lin_o        // position * STRIDE
);

  // Error must hold up to (SCR-1)+SRC before the compare.
  localparam int EW = $clog2(SRC + SCR);
  localparam logic [EW-1:0] SRC_E    = EW'(SRC);
  localparam logic [EW-1:0] SCR_E    = EW'(SCR);
  localparam logic [W-1:0]  LAST_P   = W'(SRC - 1);
  localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);

  logic [W-1:0]  pos_q, pos_d;
  logic [EW-1:0] err_q, err_d;
  logic [AW-1:0] lin_q, lin_d;
  logic [EW-1:0] err_sum;
  logic          over;
  logic          step;
  logic [AW-1:0] offset_lin;

  // Restart value offset*STRIDE built as a shift-add over the offset bits.
  always_comb begin
    offset_lin = '0;
    for (int i = 0; i < W; i++) begin
      if (offset_i[i]) offset_lin = offset_lin + (STRIDE_A << i);
    end
  end

  // Next-state: restart wins, otherwise accumulate and step with wrap to 0.
  always_comb begin
    err_sum = err_q + SRC_E;
    over    = (err_sum >= SCR_E);
    step    = advance_i && (tile_i || over);
    pos_d   = pos_q;
    err_d   = err_q;
    lin_d   = lin_q;
    if (restart_i) begin
      pos_d = offset_i;
      err_d = '0;
      lin_d = offset_lin;
    end else if (advance_i) begin
      if (!tile_i) err_d = over ? (err_sum - SCR_E) : err_sum;
      if (step) begin
        if (pos_q == LAST_P) begin
          pos_d = '0;
          lin_d = '0;
        end else begin
          pos_d = pos_q + W'(1);
          lin_d = lin_q + STRIDE_A;
        end
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      err_q <= '0;
      lin_q <= '0;
    end else begin
      pos_q <= pos_d;
      err_q <= err_d;
      lin_q <= lin_d;
    end
  end

  assign lin_o = lin_q;

endmodule

// File: rtl/bg_scaler_renderer.sv
// Full-screen background renderer: per-frame latched mode/scroll, two DDA axes
// producing a registered ROM address, then palette lookup with a delayed blank.
module bg_scaler_renderer
  import bg_render_pkg::*;
#(
  parameter int SRC_W      = 400,
  parameter int SRC_H      = 300,
  parameter int SCR_W      = SCR_W_DEFAULT,   // must be < 1024 (10-bit DrawX)
  parameter int SCR_H      = SCR_H_DEFAULT,   // must be < 1024 (10-bit DrawY)
  parameter int IDX_W      = 4,
  parameter int ADDR_W     = 17,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              mode,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              transparent
);

  localparam logic [9:0] SRC_W_C = 10'(SRC_W);
  localparam logic [9:0] SRC_H_C = 10'(SRC_H);
  localparam logic [9:0] SCR_W_C = 10'(SCR_W);
  localparam logic [9:0] SCR_H_C = 10'(SCR_H);
  localparam logic [IDX_W-1:0] TRANSP_C = IDX_W'(TRANSP_IDX);
  localparam int NSUB_X = mod_stages(SRC_W);
  localparam int NSUB_Y = mod_stages(SRC_H);

  // Frame-latched controls.
  bg_mode_e   mode_q;
  logic [9:0] sx_q;
  logic [9:0] sy_q;
  logic [9:0] last_y_q;

  // Pipeline.
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic [RENDER_LATENCY-1:0] blank_q;
  logic [3:0]                red_q, green_q, blue_q;
  logic                      transparent_q;

  logic [9:0]        sx_mod, sy_mod, sx_eff;
  logic              frame_start, in_cols, in_rows;
  logic              x_restart, x_advance, y_advance, tile;
  logic [ADDR_W-1:0] x_lin, y_lin;

  // Scroll modulo by a bounded chain of compare/subtract stages (no divider).
  always_comb begin
    sx_mod = scroll_x;
    for (int i = 0; i < NSUB_X; i++) begin
      if (sx_mod >= SRC_W_C) sx_mod = sx_mod - SRC_W_C;
    end
    sy_mod = scroll_y;
    for (int i = 0; i < NSUB_Y; i++) begin
      if (sy_mod >= SRC_H_C) sy_mod = sy_mod - SRC_H_C;
    end
  end

  // Axis control. Off-screen positions hold both accumulators. On the frame
  // start pixel the freshly reduced scroll is used so row 0 needs no extra cycle.
  always_comb begin
    frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    in_cols     = (DrawX < SCR_W_C);
    in_rows     = (DrawY < SCR_H_C);
    x_restart   = (DrawX == 10'd0) && in_rows;
    x_advance   = (DrawX != 10'd0) && in_cols && in_rows;
    y_advance   = (DrawX == 10'd0) && (DrawY != last_y_q) && (DrawY != 10'd0) && in_rows;
    tile        = (mode_q == MODE_TILE);
    sx_eff      = frame_start ? sx_mod : sx_q;
  end

  bg_dda_axis #(
    .SRC(SRC_W), .SCR(SCR_W), .STRIDE(1), .W(10), .AW(ADDR_W)
  ) u_dda_x (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .restart_i (x_restart),
    .advance_i (x_advance),
    .tile_i    (tile),
    .offset_i  (sx_eff),
    .lin_o     (x_lin)
  );

  bg_dda_axis #(
    .SRC(SRC_H), .SCR(SCR_H), .STRIDE(SRC_W), .W(10), .AW(ADDR_W)
  ) u_dda_y (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .restart_i (frame_start),
    .advance_i (y_advance),
    .tile_i    (tile),
    .offset_i  (sy_mod),
    .lin_o     (y_lin)
  );

  // Address is row base plus column; both terms stay below their source extents.
  always_comb begin
    rom_addr_d = y_lin + x_lin;
  end

  // Latch mode/scroll at the first pixel of each frame; track last row seen.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_STRETCH;
      sx_q     <= '0;
      sy_q     <= '0;
      last_y_q <= '0;
    end else begin
      last_y_q <= DrawY;
      if (frame_start) begin
        mode_q <= bg_mode_e'(mode);
        sx_q   <= sx_mod;
        sy_q   <= sy_mod;
      end
    end
  end

  // Address register, blank delay line and colour/transparency outputs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q    <= '0;
      blank_q       <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      transparent_q <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      blank_q    <= {blank_q[RENDER_LATENCY-2:0], blank};
      if (blank_q[RENDER_LATENCY-1]) begin
        red_q         <= pal_red;
        green_q       <= pal_green;
        blue_q        <= pal_blue;
        transparent_q <= (rom_q == TRANSP_C);
      end else begin
        red_q         <= '0;
        green_q       <= '0;
        blue_q        <= '0;
        transparent_q <= 1'b0;
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pal_index   = rom_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign transparent = transparent_q;

  // sy_q is kept for observability of the frame latch; it feeds nothing else.
  logic sy_unused;
  assign sy_unused = ^sy_q;

endmodule

// File: tb/tb_bg_scaler_renderer.sv
// Directed bench for bg_scaler_renderer: hand-computed address/colour points
// plus a closed-form reference (floor(x*SRC/SCR) with scroll wrap).
module tb_bg_scaler_renderer;

  localparam int SRC_W = 400;
  localparam int SRC_H = 300;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int AREA  = SRC_W * SRC_H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0, mode = 1'b0;
  logic [9:0]  scroll_x = '0, scroll_y = '0;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic [3:0]  pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        transparent;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  typedef struct {
    int addr; bit chk; bit blank; int h_addr; int h_red; int h_t; int x; int y;
  } pix_t;
  pix_t hist [4];

  bit m_valid = 1'b0;
  int m_tile, m_sx, m_sy;

  always #5 clk = ~clk;

  bg_scaler_renderer dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .mode(mode), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .transparent(transparent)
  );

  function automatic logic [3:0] rom_fn(input int a);
    if (a == 10) return 4'd0;
    return a[3:0];
  endfunction

  // Synchronous ROM and combinational palette models.
  always @(posedge clk) rom_q <= rom_fn(int'(rom_addr));
  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index + 4'd3;

  function automatic int model_addr(input int x, input int y);
    int ax, ay;
    if (m_tile != 0) begin
      ax = (m_sx + x) % SRC_W;
      ay = (m_sy + y) % SRC_H;
    end else begin
      ax = (m_sx + (x * SRC_W) / SCR_W) % SRC_W;
      ay = (m_sy + (y * SRC_H) / SCR_H) % SRC_H;
    end
    return ay * SRC_W + ax;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      check("inv_addr", longint'(int'(rom_addr) < AREA), 1);
      check("inv_xerr", longint'(int'(dut.u_dda_x.err_q) < SCR_W), 1);
      check("inv_yerr", longint'(int'(dut.u_dda_y.err_q) < SCR_H), 1);
    end
  end

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      hist[i].chk = 1'b0; hist[i].blank = 1'b0; hist[i].addr = 0;
      hist[i].h_addr = -1; hist[i].h_red = -1; hist[i].h_t = -1;
      hist[i].x = 0; hist[i].y = 0;
    end
  endtask

  // Present one pixel, clock it, then check the address of the pixel one
  // edge back and the colour outputs of the pixel three edges back.
  task automatic tick(input int x, input int y, input bit b,
                      input int h_addr = -1, input int h_red = -1, input int h_t = -1);
    pix_t ent;
    logic [3:0] idx;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    if (x == 0 && y == 0) begin
      m_tile  = int'(mode);
      m_sx    = int'(scroll_x) % SRC_W;
      m_sy    = int'(scroll_y) % SRC_H;
      m_valid = 1'b1;
    end
    ent.chk = m_valid && (x < SCR_W) && (y < SCR_H);
    ent.addr = ent.chk ? model_addr(x, y) : 0;
    ent.blank = b; ent.h_addr = h_addr; ent.h_red = h_red; ent.h_t = h_t;
    ent.x = x; ent.y = y;
    @(posedge clk); #1;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ent;
    if (hist[1].chk) check("addr", rom_addr, hist[1].addr);
    if (hist[1].h_addr >= 0) begin
      $display("pixel (%0d,%0d) rom_addr %0d want %0d", hist[1].x, hist[1].y, rom_addr, hist[1].h_addr);
      check("hand_addr", rom_addr, hist[1].h_addr);
    end
    if (hist[3].chk) begin
      idx = rom_fn(hist[3].addr);
      check("red",   red,   hist[3].blank ? idx : 4'd0);
      check("green", green, hist[3].blank ? 4'(~idx) : 4'd0);
      check("blue",  blue,  hist[3].blank ? 4'(idx + 4'd3) : 4'd0);
      check("transp", transparent, (hist[3].blank && idx == 4'd0) ? 1 : 0);
    end
    if (hist[3].h_red >= 0) begin
      $display("pixel (%0d,%0d) red %0d want %0d", hist[3].x, hist[3].y, red, hist[3].h_red);
      check("hand_red", red, hist[3].h_red);
    end
    if (hist[3].h_t >= 0) begin
      $display("pixel (%0d,%0d) transparent %0d want %0d", hist[3].x, hist[3].y, transparent, hist[3].h_t);
      check("hand_transp", transparent, hist[3].h_t);
    end
  endtask

  initial begin
    clear_hist();
    // Reset state.
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run = 1'b1;
    check("rst_addr", rom_addr, 0);
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    check("rst_transp", transparent, 0);
    reset_n = 1'b1;

    // Frame A: stretch, scroll 0. Blank gaps at x=100..103 and x=17.
    mode = 1'b0; scroll_x = 10'd0; scroll_y = 10'd0;
    for (int x = 0; x < SCR_W; x++) begin
      tick(x, 0, !((x >= 100 && x < 104) || x == 17),
           (x == 0) ? 0 : (x == 1) ? 0 : (x == 2) ? 1 : (x == 639) ? 399 : -1,
           (x == 20) ? 12 : (x == 101) ? 0 : -1,
           (x == 16) ? 1 : (x == 17) ? 0 : (x == 18) ? 0 : -1);
    end
    for (int x = 640; x < 646; x++) tick(x, 0, 1'b0);
    for (int y = 1; y < SCR_H; y++) tick(0, y, 1'b1, (y == 479) ? 119600 : -1);
    tick(0, 480, 1'b0);
    tick(0, 500, 1'b0);

    // Frame B: tile, scroll (395,298).
    mode = 1'b1; scroll_x = 10'd395; scroll_y = 10'd298;
    for (int x = 0; x < 10; x++) tick(x, 0, 1'b1, (x == 0) ? 119595 : (x == 5) ? 119200 : -1);
    tick(0, 1, 1'b1);
    tick(0, 2, 1'b1, 395);
    tick(1, 2, 1'b1);

    // Frame C: stretch, scroll 0; mode/scroll changed mid-frame at row 100.
    mode = 1'b0; scroll_x = 10'd0; scroll_y = 10'd0;
    tick(0, 0, 1'b1, 0);
    for (int y = 1; y < 100; y++) tick(0, y, 1'b1);
    scroll_x = 10'd50; mode = 1'b1;
    for (int x = 0; x < 6; x++) tick(x, 100, 1'b1, (x == 0) ? 24800 : -1);
    for (int y = 101; y < SCR_H; y++) tick(0, y, 1'b1);

    // Frame D: picks up tile/scroll 50; reset lands mid-frame at (300,200).
    tick(0, 0, 1'b1, 50);
    for (int x = 1; x < 4; x++) tick(x, 0, 1'b1, (x == 1) ? 51 : -1);
    for (int y = 1; y < 200; y++) tick(0, y, 1'b1);
    for (int x = 0; x <= 300; x++) tick(x, 200, 1'b1, (x == 0) ? 80050 : -1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_addr", rom_addr, 0);
    check("midrst_red", red, 0);
    check("midrst_green", green, 0);
    check("midrst_blue", blue, 0);
    check("midrst_transp", transparent, 0);
    clear_hist();
    m_valid = 1'b0;
    tick(301, 200, 1'b1);
    tick(302, 200, 1'b1);
    reset_n = 1'b1;
    for (int x = 303; x < 311; x++) tick(x, 200, 1'b1);
    for (int y = 201; y < 206; y++) tick(0, y, 1'b1);

    // Frame E: stretch, out-of-range scroll (807,305) reduces to (7,5).
    mode = 1'b0; scroll_x = 10'd807; scroll_y = 10'd305;
    for (int x = 0; x < SCR_W; x++) tick(x, 0, 1'b1, (x == 0) ? 2007 : -1);
    for (int y = 1; y < SCR_H; y++) tick(0, y, 1'b1, (y == 479) ? 1607 : -1);
    tick(0, 0, 1'b1, 2007);
    for (int x = 1; x < 5; x++) tick(x, 0, 1'b1);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
